// File: rtl/riscv_ifu_pkg.sv
// Shared types and constants for the NPC instruction fetch unit.
package riscv_ifu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } ifu_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_BUS      = 2'd1;
  localparam logic [1:0] FAULT_MISALIGN = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/riscv_ifu.sv
// Instruction fetch unit: one outstanding read, holds the fetched word until decode takes it.
// Optional build macro IFU_MISALIGN_CHECK_EN faults PCs with pc_i[1:0] != 0 without touching memory.
module riscv_ifu
  import riscv_ifu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_valid_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  pc_ready_o,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [INST_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic [1:0]            inst_fault_o
);

  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [1:0]            fault_q, fault_d;
  logic                  live_q;
  logic                  pc_misaligned;

`ifdef IFU_MISALIGN_CHECK_EN
  assign pc_misaligned = (pc_i[1:0] != 2'b00);
`else
  assign pc_misaligned = 1'b0;
`endif

  // live_q keeps pc_ready_o low while reset is asserted even though the FSM sits in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      fault_q <= FAULT_NONE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    fault_d      = fault_q;
    pc_ready_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    inst_valid_o = 1'b0;
    inst_o       = '0;
    inst_pc_o    = '0;
    inst_fault_o = FAULT_NONE;

    unique case (state_q)
      IDLE: begin
        pc_ready_o = live_q;
        if (live_q && pc_valid_i && !flush_i) begin
          pc_d = pc_i;
          if (pc_misaligned) begin
            inst_d  = INST_WIDTH'(INST_NOP);
            fault_d = FAULT_MISALIGN;
            state_d = HOLD;
          end else begin
            state_d = REQ;
          end
        end
      end

      // A granted request must still be drained, so flush alone cannot return to IDLE here
      REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {pc_q[ADDR_WIDTH-1:2], 2'b00};
        if (flush_i) begin
          state_d = mem_gnt_i ? DRAIN : IDLE;
        end else if (mem_gnt_i) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (flush_i) begin
          state_d = mem_rvalid_i ? IDLE : DRAIN;
        end else if (mem_rvalid_i) begin
          inst_d  = mem_rdata_i;
          fault_d = mem_err_i ? FAULT_BUS : FAULT_NONE;
          state_d = HOLD;
        end
      end

      HOLD: begin
        inst_valid_o = 1'b1;
        inst_o       = (fault_q != FAULT_NONE) ? INST_WIDTH'(INST_NOP) : inst_q;
        inst_pc_o    = pc_q;
        inst_fault_o = fault_q;
        if (flush_i || inst_ready_i) begin
          state_d = IDLE;
        end
      end

      DRAIN: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_ifu.sv
// Self-checking bench for riscv_ifu: directed scenarios plus randomized fetches against a transaction model.
module tb_riscv_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid_i;
  logic [31:0] pc_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [1:0]  inst_fault_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  riscv_ifu #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .pc_valid_i(pc_valid_i), .pc_i(pc_i), .pc_ready_o(pc_ready_o),
    .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_fault_o(inst_fault_o)
  );

  always #5 clk = ~clk;

  // A response is only legal while a fetch is waiting or draining
  always @(negedge clk) begin
    if (!rst && mem_rvalid_i)
      assert (!(pc_ready_o || mem_req_o || inst_valid_o))
        else $error("[TB] protocol: rvalid outside WAIT/DRAIN");
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_fault_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs got %h exp 0", {pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_fault_o});
    end
    step();
    checks++; if (pc_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_held got %b exp 0", pc_ready_o); end
    rst = 1'b0;
    step();
    checks++; if ({pc_ready_o, mem_req_o, inst_valid_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL reset_release got %b exp 100", {pc_ready_o, mem_req_o, inst_valid_o});
    end
  endtask

  task automatic test_basic();
    pc_valid_i = 1'b1; pc_i = 32'h8000_0000; step(); pc_valid_i = 1'b0;
    checks++; if ({mem_req_o, mem_addr_o, pc_ready_o} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      errors++; $display("[TB] FAIL basic_req got %b/%h exp 1/80000000", mem_req_o, mem_addr_o);
    end
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    checks++; if ({mem_req_o, inst_valid_o} !== 2'b00) begin
      errors++; $display("[TB] FAIL basic_wait got %b exp 00", {mem_req_o, inst_valid_o});
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0010_0093; step(); mem_rvalid_i = 1'b0;
    checks++; if ({inst_valid_o, pc_ready_o, inst_o, inst_pc_o, inst_fault_o} !== {2'b10, 32'h0010_0093, 32'h8000_0000, 2'd0}) begin
      errors++; $display("[TB] FAIL basic_hold got v=%b i=%h pc=%h f=%0d exp 1/00100093/80000000/0", inst_valid_o, inst_o, inst_pc_o, inst_fault_o);
    end
    inst_ready_i = 1'b1; step(); inst_ready_i = 1'b0;
    checks++; if ({inst_valid_o, pc_ready_o} !== 2'b01) begin
      errors++; $display("[TB] FAIL basic_handoff got %b exp 01", {inst_valid_o, pc_ready_o});
    end
  endtask

  task automatic test_gnt_delay();
    int req_cycles;
    req_cycles = 0;
    pc_valid_i = 1'b1; pc_i = 32'h8000_0004; step(); pc_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_cycles += int'(mem_req_o);
      checks++; if (mem_addr_o !== 32'h8000_0004) begin
        errors++; $display("[TB] FAIL gnt_delay_addr cycle %0d got %h exp 80000004", k, mem_addr_o);
      end
      if (k == 3) mem_gnt_i = 1'b1;
      step();
    end
    mem_gnt_i = 1'b0;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL gnt_delay_drop got %b exp 0", mem_req_o); end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0020_0113; step(); mem_rvalid_i = 1'b0;
    req_cycles += int'(mem_req_o);
    checks++; if ({inst_valid_o, inst_o} !== {1'b1, 32'h0020_0113}) begin
      errors++; $display("[TB] FAIL gnt_delay_inst got %b/%h exp 1/00200113", inst_valid_o, inst_o);
    end
    inst_ready_i = 1'b1; step(); inst_ready_i = 1'b0;
    checks++; if (req_cycles !== 4) begin errors++; $display("[TB] FAIL gnt_delay_req_count got %0d exp 4", req_cycles); end
  endtask

  task automatic test_flush_wait();
    pc_valid_i = 1'b1; pc_i = 32'h8000_0008; step(); pc_valid_i = 1'b0;
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    flush_i = 1'b1; step();
    // second flush lands in DRAIN and must not shorten it
    step(); flush_i = 1'b0;
    checks++; if ({pc_ready_o, inst_valid_o, mem_req_o} !== 3'b000) begin
      errors++; $display("[TB] FAIL flush_wait_drain got %b exp 000", {pc_ready_o, inst_valid_o, mem_req_o});
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; step(); mem_rvalid_i = 1'b0;
    checks++; if ({pc_ready_o, inst_valid_o} !== 2'b10) begin
      errors++; $display("[TB] FAIL flush_wait_done got %b exp 10", {pc_ready_o, inst_valid_o});
    end
    step();
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_wait_no_inst got %b exp 0", inst_valid_o); end
  endtask

  task automatic test_flush_req();
    pc_valid_i = 1'b1; flush_i = 1'b1; pc_i = 32'h8000_0040; step(); pc_valid_i = 1'b0; flush_i = 1'b0;
    checks++; if ({pc_ready_o, mem_req_o} !== 2'b10) begin
      errors++; $display("[TB] FAIL flush_idle_priority got %b exp 10", {pc_ready_o, mem_req_o});
    end
    pc_valid_i = 1'b1; step(); pc_valid_i = 1'b0;
    flush_i = 1'b1; step(); flush_i = 1'b0;
    checks++; if ({pc_ready_o, mem_req_o} !== 2'b10) begin
      errors++; $display("[TB] FAIL flush_req_withdraw got %b exp 10", {pc_ready_o, mem_req_o});
    end
    pc_valid_i = 1'b1; step(); pc_valid_i = 1'b0;
    flush_i = 1'b1; mem_gnt_i = 1'b1; step(); flush_i = 1'b0; mem_gnt_i = 1'b0;
    checks++; if ({pc_ready_o, mem_req_o, inst_valid_o} !== 3'b000) begin
      errors++; $display("[TB] FAIL flush_req_gnt_drain got %b exp 000", {pc_ready_o, mem_req_o, inst_valid_o});
    end
    mem_rvalid_i = 1'b1; step(); mem_rvalid_i = 1'b0;
    checks++; if ({pc_ready_o, inst_valid_o} !== 2'b10) begin
      errors++; $display("[TB] FAIL flush_req_gnt_done got %b exp 10", {pc_ready_o, inst_valid_o});
    end
  endtask

  task automatic test_bus_error();
    pc_valid_i = 1'b1; pc_i = 32'h8000_0010; step(); pc_valid_i = 1'b0;
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h1234_5678; step();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    checks++; if ({inst_valid_o, inst_fault_o, inst_o, inst_pc_o} !== {1'b1, 2'd1, NOP, 32'h8000_0010}) begin
      errors++; $display("[TB] FAIL bus_error got v=%b f=%0d i=%h pc=%h exp 1/1/00000013/80000010", inst_valid_o, inst_fault_o, inst_o, inst_pc_o);
    end
    inst_ready_i = 1'b1; step(); inst_ready_i = 1'b0;
  endtask

  task automatic test_hold_stall();
    pc_valid_i = 1'b1; pc_i = 32'h8000_0020; step(); pc_valid_i = 1'b0;
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0041_8193; step(); mem_rvalid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({inst_valid_o, pc_ready_o, inst_o, inst_pc_o, inst_fault_o} !== {2'b10, 32'h0041_8193, 32'h8000_0020, 2'd0}) begin
        errors++; $display("[TB] FAIL hold_stall cycle %0d got v=%b r=%b i=%h pc=%h", k, inst_valid_o, pc_ready_o, inst_o, inst_pc_o);
      end
      step();
    end
    inst_ready_i = 1'b1; step(); inst_ready_i = 1'b0;
    checks++; if ({inst_valid_o, pc_ready_o} !== 2'b01) begin
      errors++; $display("[TB] FAIL hold_release got %b exp 01", {inst_valid_o, pc_ready_o});
    end
  endtask

  task automatic test_misalign();
    pc_valid_i = 1'b1; pc_i = 32'h8000_0002; step(); pc_valid_i = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    checks++; if ({mem_req_o, inst_valid_o, inst_fault_o, inst_o, inst_pc_o} !== {2'b01, 2'd2, NOP, 32'h8000_0002}) begin
      errors++; $display("[TB] FAIL misalign got r=%b v=%b f=%0d i=%h pc=%h", mem_req_o, inst_valid_o, inst_fault_o, inst_o, inst_pc_o);
    end
`else
    checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h8000_0000}) begin
      errors++; $display("[TB] FAIL misalign_addr got %b/%h exp 1/80000000", mem_req_o, mem_addr_o);
    end
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0297; step(); mem_rvalid_i = 1'b0;
    checks++; if ({inst_valid_o, inst_fault_o, inst_o, inst_pc_o} !== {1'b1, 2'd0, 32'h0000_0297, 32'h8000_0002}) begin
      errors++; $display("[TB] FAIL misalign_fetch got v=%b f=%0d i=%h pc=%h", inst_valid_o, inst_fault_o, inst_o, inst_pc_o);
    end
`endif
    inst_ready_i = 1'b1; step(); inst_ready_i = 1'b0;
  endtask

  // One fetch checked against the expected outcome; fp: 0 none, 1 flush in REQ, 2 flush in WAIT, 3 flush in HOLD
  task automatic run_txn(input logic [31:0] pc, input logic [31:0] data, input logic err,
                         input int gd, input int rd, input int yd, input int fp);
    logic [31:0] exp_addr, exp_inst;
    logic [1:0]  exp_fault;
    exp_addr  = {pc[31:2], 2'b00};
    exp_inst  = err ? NOP : data;
    exp_fault = err ? 2'd1 : 2'd0;
    checks++; if (pc_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rnd_ready_start got %b exp 1", pc_ready_o); end
    pc_valid_i = 1'b1; pc_i = pc; step(); pc_valid_i = 1'b0;
    for (int k = 0; k <= gd; k++) begin
      checks++; if ({mem_req_o, mem_addr_o} !== {1'b1, exp_addr}) begin
        errors++; $display("[TB] FAIL rnd_req got %b/%h exp 1/%h", mem_req_o, mem_addr_o, exp_addr);
      end
      if (fp == 1) begin
        flush_i = 1'b1; step(); flush_i = 1'b0;
        checks++; if ({pc_ready_o, mem_req_o} !== 2'b10) begin
          errors++; $display("[TB] FAIL rnd_flush_req got %b exp 10", {pc_ready_o, mem_req_o});
        end
        return;
      end
      if (k == gd) mem_gnt_i = 1'b1;
      step();
    end
    mem_gnt_i = 1'b0;
    if (fp == 2) begin
      flush_i = 1'b1; step(); flush_i = 1'b0;
    end
    for (int k = 1; k < rd; k++) begin
      checks++; if ({pc_ready_o, inst_valid_o, mem_req_o} !== 3'b000) begin
        errors++; $display("[TB] FAIL rnd_wait got %b exp 000", {pc_ready_o, inst_valid_o, mem_req_o});
      end
      step();
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = data; mem_err_i = err; step();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    if (fp == 2) begin
      checks++; if ({pc_ready_o, inst_valid_o} !== 2'b10) begin
        errors++; $display("[TB] FAIL rnd_flush_wait got %b exp 10", {pc_ready_o, inst_valid_o});
      end
      return;
    end
    for (int k = 0; k <= yd; k++) begin
      checks++; if ({inst_valid_o, pc_ready_o, inst_o, inst_pc_o, inst_fault_o} !== {2'b10, exp_inst, pc, exp_fault}) begin
        errors++; $display("[TB] FAIL rnd_hold got v=%b i=%h pc=%h f=%0d exp %h/%h/%0d", inst_valid_o, inst_o, inst_pc_o, inst_fault_o, exp_inst, pc, exp_fault);
      end
      if (fp == 3) begin
        flush_i = 1'b1; step(); flush_i = 1'b0;
        checks++; if ({inst_valid_o, pc_ready_o} !== 2'b01) begin
          errors++; $display("[TB] FAIL rnd_flush_hold got %b exp 01", {inst_valid_o, pc_ready_o});
        end
        return;
      end
      if (k == yd) inst_ready_i = 1'b1;
      step();
    end
    inst_ready_i = 1'b0;
    checks++; if ({inst_valid_o, pc_ready_o} !== 2'b01) begin
      errors++; $display("[TB] FAIL rnd_handoff got %b exp 01", {inst_valid_o, pc_ready_o});
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, data;
    logic        err;
    int          gd, rd, yd, fp;
    for (int n = 0; n < 60; n++) begin
      pc = $urandom;
`ifdef IFU_MISALIGN_CHECK_EN
      pc[1:0] = 2'b00;
`endif
      data = $urandom;
      err  = ($urandom_range(0, 3) == 0);
      gd   = $urandom_range(0, 3);
      rd   = $urandom_range(1, 3);
      yd   = $urandom_range(0, 3);
      fp   = $urandom_range(0, 6);
      if (fp > 3) fp = 0;
      run_txn(pc, data, err, gd, rd, yd, fp);
    end
  endtask

  task automatic test_reset_mid();
    pc_valid_i = 1'b1; pc_i = 32'h8000_0030; step(); pc_valid_i = 1'b0;
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_fault_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_mid_outputs got %h exp 0", {pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_fault_o});
    end
    step();
    rst = 1'b0;
    step();
    checks++; if ({pc_ready_o, mem_req_o, inst_valid_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL reset_mid_recover got %b exp 100", {pc_ready_o, mem_req_o, inst_valid_o});
    end
  endtask

  initial begin
    rst = 1'b1; pc_valid_i = 1'b0; pc_i = '0; flush_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    inst_ready_i = 1'b0;
    $display("[TB] riscv_ifu bench start");
    test_reset();
    test_basic();
    test_gnt_delay();
    test_flush_wait();
    test_flush_req();
    test_bus_error();
    test_hold_stall();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
